// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Wallace multiplier: widths, stage count,
// operation mode bundle and the reduction-tree row-count helpers.
package mul_pkg;

    localparam int MUL_STAGES = 3;

    typedef struct packed {
        logic sgn;
        logic approx;
    } op_mode_t;

    function automatic int PW(input int width);
        return 2 * width;
    endfunction

    // One 3:2 layer turns every full group of three rows into two.
    function automatic int rows_next(input int n);
        return n - n / 3;
    endfunction

    function automatic int rows_at(input int n0, input int layers);
        int n;
        n = n0;
        for (int k = 0; k < layers; k++) n = rows_next(n);
        return n;
    endfunction

    function automatic int tree_layers(input int n0);
        int n;
        int c;
        n = n0;
        c = 0;
        while (n > 2) begin
            n = rows_next(n);
            c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/csa_layer.sv
// Column-aligned 3:2 compressor row: one full adder per column, carries moved
// up one column and the top carry dropped (results are modulo 2^W).
module csa_layer #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage Wallace-tree multiplier with valid/ready flow control, per-operation
// signed (Baugh-Wooley) and LSB-truncated approximate modes, and a tag sideband.
module wallace_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TRUNC_K = 4,
    parameter int TAG_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 sgn_i,
    input  logic                 approx_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result_o,
    output logic [TAG_W-1:0]     tag_o
);

    localparam int PROD_W = PW(WIDTH);
    localparam int N0     = WIDTH + 1;
    localparam int NLAY   = tree_layers(N0);
    localparam int L1     = (NLAY + 1) / 2;
    localparam int R1     = rows_at(N0, L1);

    // Baugh-Wooley correction: +2^W and +2^(2W-1), modulo 2^(2W).
    localparam logic [PROD_W-1:0] BW_CONST  = (PROD_W'(1) << WIDTH) | (PROD_W'(1) << (PROD_W - 1));
    localparam logic [PROD_W-1:0] CMP_CONST = (TRUNC_K > 0) ?
        (PROD_W'(1) << ((TRUNC_K > 0) ? TRUNC_K - 1 : 0)) : '0;

    op_mode_t                  mode_s0;
    logic [WIDTH-1:0]          row_s0;
    logic [PROD_W-1:0]         pp_s0 [0:N0-1];
    logic [PROD_W-1:0]         tr    [0:NLAY][0:N0-1];
    logic [PROD_W-1:0]         lin   [0:NLAY-1][0:N0-1];
    logic [R1-1:0][PROD_W-1:0] front_s0;

    logic                      vld_p0, vld_p1, vld_p2;
    logic                      en_p0, en_p1, en_p2;
    logic [R1-1:0][PROD_W-1:0] rows_p0;
    logic [TAG_W-1:0]          tag_p0, tag_p1, tag_p2;
    logic [PROD_W-1:0]         sum_p1, car_p1, res_p2;

    assign mode_s0 = '{sgn: sgn_i, approx: approx_i};

    always_comb begin
        row_s0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                row_s0[j] = a_i[j] & b_i[i];
                if (mode_s0.sgn && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                    row_s0[j] = ~row_s0[j];
                if (!mode_s0.sgn && mode_s0.approx && (i + j < TRUNC_K))
                    row_s0[j] = 1'b0;
            end
            pp_s0[i] = {{WIDTH{1'b0}}, row_s0} << i;
        end
        pp_s0[WIDTH] = mode_s0.sgn ? BW_CONST : (mode_s0.approx ? CMP_CONST : '0);
    end

    // Reduction tree: layers below L1 sit in S1, the rest read the S1 register.
    for (genvar r = 0; r < N0; r++) begin : g_pp
        assign tr[0][r] = pp_s0[r];
    end

    for (genvar l = 0; l < NLAY; l++) begin : g_lay
        localparam int NIN  = rows_at(N0, l);
        localparam int NG   = NIN / 3;
        localparam int NOUT = NIN - NG;

        for (genvar r = 0; r < N0; r++) begin : g_src
            if (l == L1) begin : g_reg
                if (r < R1) begin : g_row
                    assign lin[l][r] = rows_p0[r];
                end else begin : g_pad
                    assign lin[l][r] = '0;
                end
            end else begin : g_comb
                assign lin[l][r] = tr[l][r];
            end
        end

        for (genvar g = 0; g < NG; g++) begin : g_csa
            csa_layer #(.W(PROD_W)) u_csa (
                .x     (lin[l][3*g]),
                .y     (lin[l][3*g+1]),
                .z     (lin[l][3*g+2]),
                .sum   (tr[l+1][2*g]),
                .carry (tr[l+1][2*g+1])
            );
        end

        for (genvar r = 3 * NG; r < NIN; r++) begin : g_pass
            assign tr[l+1][r-NG] = lin[l][r];
        end

        for (genvar r = NOUT; r < N0; r++) begin : g_zero
            assign tr[l+1][r] = '0;
        end
    end

    for (genvar r = 0; r < R1; r++) begin : g_front
        assign front_s0[r] = tr[L1][r];
    end

    assign en_p2    = !vld_p2 || out_ready;
    assign en_p1    = !vld_p1 || en_p2;
    assign en_p0    = !vld_p0 || en_p1;
    assign in_ready = en_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (en_p0) vld_p0 <= in_valid;
            if (en_p1) vld_p1 <= vld_p0;
            if (en_p2) vld_p2 <= vld_p1;
        end
    end

    // S1 -> S2 boundary: partially reduced rows; S2 -> S3 boundary: sum/carry pair.
    always_ff @(posedge clk) begin
        if (en_p0 && in_valid) begin
            rows_p0 <= front_s0;
            tag_p0  <= tag_i;
        end
        if (en_p1 && vld_p0) begin
            sum_p1 <= tr[NLAY][0];
            car_p1 <= tr[NLAY][1];
            tag_p1 <= tag_p0;
        end
    end

    // S3: final carry-propagate add into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p2 <= '0;
            tag_p2 <= '0;
        end else if (en_p2 && vld_p1) begin
            res_p2 <= sum_p1 + car_p1;
            tag_p2 <= tag_p1;
        end
    end

    assign out_valid = vld_p2;
    assign result_o  = res_p2;
    assign tag_o     = tag_p2;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Randomised and directed bench for wallace_mul_pipe: an 8-bit instance for flow
// control, stalls and reset, and a 4-bit instance swept over every operand pair.
module tb_wallace_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, sgn, apx, out_valid, out_ready;
    logic [7:0] a, b;
    logic [3:0] tag, tag_o;
    logic [15:0] result;

    logic       in_valid4, in_ready4, sgn4, apx4, out_valid4, out_ready4;
    logic [3:0] a4, b4, tag4, tag_o4;
    logic [7:0] result4;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  tag;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t pending8;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out8  = 0;
    bit   acc8, acc4;

    wallace_mul_pipe #(.WIDTH(8), .TRUNC_K(4), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_i(a), .b_i(b), .sgn_i(sgn), .approx_i(apx), .tag_i(tag),
        .out_valid(out_valid), .out_ready(out_ready), .result_o(result), .tag_o(tag_o)
    );

    wallace_mul_pipe #(.WIDTH(4), .TRUNC_K(2), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a_i(a4), .b_i(b4), .sgn_i(sgn4), .approx_i(apx4), .tag_i(tag4),
        .out_valid(out_valid4), .out_ready(out_ready4), .result_o(result4), .tag_o(tag_o4)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Product as plain integer arithmetic; approximate mode removes, row by row,
    // the multiplicand bits whose column falls below k, then adds 2^(k-1).
    function automatic longint ref_mul(input int w, input int k, input longint ua,
                                       input longint ub, input bit s, input bit x);
        longint sa, sb, p, mask;
        mask = (longint'(1) << (2 * w)) - 1;
        sa = ua;
        sb = ub;
        if (s) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
            p = sa * sb;
        end else begin
            p = sa * sb;
            if (x && k > 0) begin
                for (int i = 0; i < k; i++)
                    if (((sb >> i) & 1) == 1) p = p - ((sa % (longint'(1) << (k - i))) << i);
                p = p + (longint'(1) << (k - 1));
            end
        end
        return p & mask;
    endfunction

    task automatic tick();
        exp_t e;
        #1;
        acc8 = in_valid && in_ready;
        acc4 = in_valid4 && in_ready4;
        if (out_valid && out_ready) begin
            n_out8++;
            if (q8.size() == 0) check("dut8_spurious_out", 64'(1), 64'(0));
            else begin
                e = q8.pop_front();
                check("dut8_result", 64'(result), 64'(e.res));
                check("dut8_tag", 64'(tag_o), 64'(e.tag));
            end
        end
        if (out_valid4 && out_ready4) begin
            if (q4.size() == 0) check("dut4_spurious_out", 64'(1), 64'(0));
            else begin
                e = q4.pop_front();
                check("dut4_result", 64'(result4), 64'(e.res));
                check("dut4_tag", 64'(tag_o4), 64'(e.tag));
            end
        end
        if (acc8) q8.push_back(pending8);
        if (acc4) q4.push_back('{res: 16'(ref_mul(4, 2, 64'(a4), 64'(b4), sgn4, apx4)), tag: tag4});
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                      input logic ix, input logic [3:0] it, input logic [15:0] want);
        int n;
        a = ia; b = ib; sgn = is; apx = ix; tag = it;
        pending8 = '{res: want, tag: it};
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc8 && n < 20);
        if (!acc8) check("op_accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic lat_op(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] it,
                          input logic [15:0] want);
        op(ia, ib, 1'b0, 1'b0, it, want);
        check("latency_edge1_valid", 64'(out_valid), 64'(0));
        tick();
        check("latency_edge2_valid", 64'(out_valid), 64'(0));
        tick();
        check("latency_edge3_valid", 64'(out_valid), 64'(1));
        check("latency_edge3_result", 64'(result), 64'(want));
        check("latency_edge3_tag", 64'(tag_o), 64'(it));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() + q4.size()) > 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_left", 64'(q8.size() + q4.size()), 64'(0));
        tick();
        check("idle_out_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic new_rand8(input int i);
        a   = 8'($urandom);
        b   = 8'($urandom);
        sgn = 1'($urandom_range(0, 1));
        apx = 1'($urandom_range(0, 1));
        tag = 4'(i);
        pending8 = '{res: 16'(ref_mul(8, 4, 64'(a), 64'(b), sgn, apx)), tag: tag};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k, sent, outs0;
        logic [15:0] held_r;
        logic [3:0]  held_t;

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; apx = 1'b0; tag = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sgn4 = 1'b0; apx4 = 1'b0; tag4 = '0; out_ready4 = 1'b1;
        pending8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_tag", 64'(tag_o), 64'(0));
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));

        lat_op(8'hFF, 8'hFF, 4'h5, 16'hFE01);
        drain();

        op(8'h80, 8'h80, 1'b1, 1'b0, 4'h1, 16'h4000);
        op(8'hFF, 8'h01, 1'b1, 1'b0, 4'h2, 16'hFFFF);
        op(8'h7F, 8'h80, 1'b1, 1'b0, 4'h3, 16'hC080);
        op(8'h0F, 8'h0F, 1'b0, 1'b1, 4'h4, 16'h00B8);
        op(8'h0F, 8'h0F, 1'b0, 1'b0, 4'h5, 16'h00E1);
        op(8'h0F, 8'h0F, 1'b1, 1'b1, 4'h6, 16'h00E1);
        op(8'hFF, 8'hFF, 1'b0, 1'b1, 4'h7, 16'hFDD8);
        drain();

        // 16-operation stream with the consumer stalled for cycles 5..9.
        k = 0;
        sent = 0;
        outs0 = n_out8;
        held_r = '0;
        held_t = '0;
        new_rand8(0);
        while ((sent < 16 || q8.size() > 0) && k < 200) begin
            out_ready = !(k >= 5 && k <= 9);
            in_valid  = (sent < 16);
            #1;
            if (k == 5) begin
                held_r = result;
                held_t = tag_o;
                check("stall_in_ready", 64'(in_ready), 64'(0));
                check("stall_out_valid", 64'(out_valid), 64'(1));
            end else if (k > 5 && k <= 9) begin
                check("stall_result_hold", 64'(result), 64'(held_r));
                check("stall_tag_hold", 64'(tag_o), 64'(held_t));
                check("stall_in_ready", 64'(in_ready), 64'(0));
            end
            tick();
            if (acc8) begin
                sent++;
                if (sent < 16) new_rand8(sent);
            end
            k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_results", 64'(n_out8 - outs0), 64'(16));
        drain();

        // Asynchronous reset with work in flight, then a fresh operation.
        op(8'h12, 8'h34, 1'b0, 1'b0, 4'h9, 16'h03A8);
        op(8'h56, 8'h78, 1'b0, 1'b0, 4'hB, 16'h2850);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'(0));
        check("async_reset_result", 64'(result), 64'(0));
        check("async_reset_tag", 64'(tag_o), 64'(0));
        q8.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'(1));
        lat_op(8'h03, 8'h05, 4'hA, 16'h000F);
        drain();

        // Every operand pair of the 4-bit instance in unsigned, approximate and signed modes.
        for (int i = 0; i < 768; i++) begin
            a4   = 4'(i);
            b4   = 4'(i / 16);
            sgn4 = (i / 256) == 2;
            apx4 = (i / 256) == 1;
            tag4 = 4'(i * 7);
            in_valid4 = 1'b1;
            tick();
            if (!acc4) check("dut4_accept", 64'(0), 64'(1));
        end
        in_valid4 = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wallace_mul_pipe.md
Name: wallace_mul_pipe

Overview:
- Parametrised, pipelined unsigned/signed array multiplier. Partial products are reduced by a Wallace carry-save tree, then resolved by a final carry-propagate add.
- Successor to the fixed 8x8 combinational Wallace multiplier, adding:
  - operand width parameter;
  - a 3-stage pipeline with valid/ready backpressure;
  - a per-transaction signed mode;
  - a per-transaction approximate (LSB-column truncation) mode;
  - a tag passthrough.
- Sits between operand producers and accumulator/datapath consumers in the approximate-multiplier evaluation fabric.

Parameters:
- WIDTH, 8, operand width in bits (legal range 4..32). Product width is 2*WIDTH.
- TRUNC_K, 4, number of low product columns whose partial-product bits are dropped in approximate mode (0..WIDTH). A value of 0 makes approximate mode exact.
- TAG_W, 4, width of the sideband tag carried alongside each operation (at least 1).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset: asynchronous assert, active-low.
- in_valid, input, 1, operand pair presented.
- in_ready, output, 1, stage 1 can accept this cycle.
- a_i, input, WIDTH, multiplicand.
- b_i, input, WIDTH, multiplier.
- sgn_i, input, 1, 1 = both operands two's complement; 0 = unsigned.
- approx_i, input, 1, 1 = truncated (approximate) product. Honoured only when sgn_i = 0.
- tag_i, input, TAG_W, sideband tag, returned unchanged with the result.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- result_o, output, 2*WIDTH, product.
- tag_o, output, TAG_W, tag of the current result.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - All stage valid bits clear; out_valid = 0; result_o = 0; tag_o = 0.
  - in_ready = 1 immediately after reset is released.
  - An operation in flight at reset is discarded; no partial result is ever emitted.
- Transfers: a transfer occurs when valid and ready are both high on a rising edge (in_valid & in_ready, out_valid & out_ready).
- Pipeline:
  - S1: partial-product generation plus the first carry-save reduction layers.
  - S2: remaining reduction down to two rows.
  - S3: final carry-propagate add; output register.
- Latency: 3 cycles from the input transfer to out_valid with no stalls. Throughput is one result per cycle.
- Backpressure:
  - Stage k may load when it is empty or when stage k+1 loads/drains that cycle. in_ready is the S1 load condition.
  - Bubbles collapse: empty stages fill even while out_ready = 0.
  - While out_valid = 1 and out_ready = 0, result_o and tag_o hold stable.
  - in_ready must not combinationally depend on in_valid.
- Ordering: results leave in acceptance order, each with its own tag. There is no drop and no duplication.
- Unsigned mode: result_o = a_i * b_i, exact, modulo 2^(2*WIDTH). No overflow is possible.
- Signed mode: Baugh-Wooley partial-product matrix. result_o equals the two's-complement product, exact. approx_i is ignored.
- Approximate mode (sgn_i = 0, approx_i = 1):
  - Every partial-product bit a[j]&b[i-j] with column index i < TRUNC_K is forced to 0.
  - If TRUNC_K > 0, a compensation constant 2^(TRUNC_K-1) is added into the tree.
  - result_o = exact product − (sum of dropped bit weights) + compensation. This is an arithmetic identity; there is no saturation. Columns at or above TRUNC_K are exact.
- Mode, sgn and tag are captured at S1 with the operands and travel with them. A mode change between back-to-back operations takes effect per operation with no bubble.
- Simultaneous S3 drain and S1 accept on the same edge is legal and must sustain full throughput.

Decomposition:
- Shared package mul_pkg holds:
  - product-width function PW(WIDTH) = 2*WIDTH;
  - pipeline-stage count constant MUL_STAGES = 3;
  - typedef for the stage payload struct {valid, sgn, approx, tag, row vectors}.
- One natural sub-module: csa_layer, a parametrised row of full/half adders that compresses 3 rows into 2 with column alignment. Instantiated per reduction layer by a generate loop.
- The final carry-propagate add stays inline.

Test Plan:
- WIDTH = 8, unsigned, a = 0xFF, b = 0xFF, out_ready = 1 -> result_o = 0xFE01 exactly 3 cycles after the transfer; tag echoed.
- Signed, a = 0x80, b = 0x80 -> 0x4000. Signed a = 0xFF, b = 0x01 -> 0xFFFF. Signed a = 0x7F, b = 0x80 -> 0xC080.
- Approximate, TRUNC_K = 4, a = 0x0F, b = 0x0F -> 0x00B8 (225 − 49 + 8). The same operands with approx_i = 0 -> 0x00E1.
- Back-to-back stream of 16 operations with random sgn/approx, out_ready low for cycles 5–9:
  - in_ready falls after 3 results are buffered;
  - result_o and tag_o stay stable while stalled;
  - all 16 results appear in order, each matching the reference model, with no loss.
- rst_n pulsed low asynchronously mid-cycle with 2 operations in flight -> out_valid = 0 and result_o = 0 immediately; after release, the next operation 3 × 5 (unsigned) -> 0x000F with latency 3.
- Exhaustive sweep at WIDTH = 4 and TRUNC_K = 2, all 256 operand pairs × 3 modes, against the scoreboard formulas above.
